mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Parametrised memory-bus arbiter that replaces the fixed two-way address mux between the 6502 fetch and execute units with an N-requester, registered-grant arbiter. It sits between the CPU-side masters (instruction fetch, instruction execute, OAM DMA, debug port) and the single shared NES memory bus. It adds fixed-priority or round-robin selection, bus locking for multi-cycle sequences, a lock timeout against starvation, halt gating and per-requester read-data-valid strobes.

## Interface

- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 16, address width
- DATA_W, 8, data width
- RR_MODE, 0, 0 = fixed priority (index 0 highest), 1 = round robin
- LOCK_MAX, 64, maximum consecutive cycles one locked owner may hold the bus (≥2)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  N_REQ  per-requester bus request, level
- lock  in  N_REQ  owner requests to keep the bus after the current cycle
- we  in  N_REQ  per-requester write strobe (valid with req)
- re  in  N_REQ  per-requester read strobe (valid with req)
- addr  in  N_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
- wdata  in  N_REQ*DATA_W  flattened write data, same packing
- halt  in  1  freezes arbitration and suppresses bus strobes
- gnt  out  N_REQ  one-hot registered grant (all-zero when idle)
- mem_addr  out  ADDR_W  shared bus address
- mem_data_out  out  DATA_W  shared bus write data
- mem_write_en  out  1  shared bus write strobe
- mem_read_en  out  1  shared bus read strobe
- rd_valid  out  N_REQ  one-cycle strobe: mem_data_in is valid for requester i
- busy  out  1  gnt != 0

## Operation

- States: IDLE (no owner), OWN (owner index registered, gnt one-hot on owner).
- IDLE: if any req, pick winner; next cycle OWN with gnt[winner]=1. No req → stay IDLE.
- OWN: bus driven combinationally from owner: mem_addr=addr[owner], mem_data_out=wdata[owner], mem_write_en=req[owner]&we[owner]&~halt, mem_read_en=req[owner]&re[owner]&~halt&~(write). we and re both set → write wins.
- OWN retention: stay with same owner if req[owner]&lock[owner] and lock counter < LOCK_MAX-1. Otherwise re-arbitrate at end of cycle (winner may be same owner, if it still requests and wins); no req → IDLE.
- Fixed priority: lowest-index asserted req wins.
- Round robin: search starts at (last_owner+1) mod N_REQ, wraps; after reset last_owner = N_REQ-1 so index 0 searched first.
- Lock counter: cleared on every owner change and in IDLE; increments each OWN cycle with lock retention; on reaching LOCK_MAX-1 forces re-arbitration and in RR mode excludes the expired owner from that one arbitration if any other req is asserted.
- Owner dropping req while granted: bus strobes deassert that cycle; re-arbitration at end of cycle.
- halt=1: gnt, owner, counter, RR pointer frozen; mem_write_en=mem_read_en=0; no arbitration. rd_valid for a read issued the cycle before halt still fires.
- rd_valid[i]=1 exactly one cycle after a cycle where mem_read_en=1 with owner i (memory has one-cycle read latency).
- mem_addr/mem_data_out = 0 in IDLE.

## Timing

- Reset (rst=0, asynchronous): state IDLE, gnt=0, rd_valid=0, busy=0, counter=0, RR pointer=N_REQ-1; mem_* outputs all 0.
- Request latency: req[i] rising at edge k, with bus IDLE and i winning → gnt[i] at k+1, first strobe in cycle k+1, rd_valid[i] at k+2.
- Handover: owner without lock loses gnt one cycle after its request cycle; new owner's strobe immediately in that cycle (zero dead cycles).
- Back-to-back accesses by one locked owner: one access per cycle.
- Reset asserted mid-access: all outputs 0 immediately (asynchronous), pending rd_valid discarded.
- gnt is never multi-hot; rd_valid never multi-hot.

## Test plan

- Reset: rst=0 with req=4'b1111 → gnt=0, strobes 0; release rst → gnt=4'b0001 one cycle later (both modes).
- Fixed priority: req=4'b1010 held, no lock → gnt=4'b0010 every cycle; req[1] drops → gnt=4'b1000 next cycle.
- Round robin (RR_MODE=1): req=4'b1111 held, no lock → gnt sequence 0001,0010,0100,1000,0001.
- Lock and timeout (LOCK_MAX=4, RR): req=4'b0011, lock[0]=1 → gnt[0] for 4 cycles, then gnt=4'b0010.
- Read valid: owner 2 reads addr 16'h2002 → mem_read_en=1, mem_addr=16'h2002; rd_valid=4'b0100 next cycle only; we+re both set → only mem_write_en.
- Halt: assert halt during owner 1 → strobes 0, gnt stays 4'b0010, RR pointer frozen; deassert → accesses resume in same order.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory bus between N_REQ masters (fetch, execute, OAM DMA, debug).
//   The grant is registered. Selection is fixed-priority (index 0 highest) or
//   round robin. A master can lock the bus for multi-cycle sequences. A lock
//   counter bounds how long one locked master may keep the bus.
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   ADDR_W   address width
//   DATA_W   data width
//   RR_MODE  0 = fixed priority, 1 = round robin
//   LOCK_MAX maximum consecutive cycles one locked owner may hold the bus (>= 2)
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   req/lock     per-requester request and keep-bus request
//   we/re        per-requester write/read strobes, qualified by req
//   addr/wdata   flattened per-requester address and write data
//                (requester i occupies slice i)
//   halt         freezes arbitration and masks the bus strobes
//   gnt          one-hot registered grant
//   mem_*        shared bus signals, driven from the current owner
//   rd_valid     read data for requester i is valid this cycle
//   busy         a grant is active
module mem_bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int RR_MODE  = 0,
  parameter int LOCK_MAX = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          lock,
  input  logic [N_REQ-1:0]          we,
  input  logic [N_REQ-1:0]          re,
  input  logic [N_REQ*ADDR_W-1:0]   addr,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  input  logic                      halt,
  output logic [N_REQ-1:0]          gnt,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_data_out,
  output logic                      mem_write_en,
  output logic                      mem_read_en,
  output logic [N_REQ-1:0]          rd_valid,
  output logic                      busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(LOCK_MAX - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   owner_reg, owner_next;
  logic [IDX_W-1:0]   last_reg, last_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [N_REQ-1:0]   gnt_reg, gnt_next;
  logic [N_REQ-1:0]   rd_valid_reg, rd_valid_next;

  // Unpack the flattened request buses so the owner mux is a plain array index.
  logic [ADDR_W-1:0] addr_arr  [N_REQ];
  logic [DATA_W-1:0] wdata_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = addr[gi*ADDR_W +: ADDR_W];
      assign wdata_arr[gi] = wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Winner selection
  logic             expired;
  logic [N_REQ-1:0] owner_mask;
  logic [N_REQ-1:0] cand;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  int               idx;

  assign expired = (state_reg == OWN) && (cnt_reg >= CNT_LIMIT);

  always_comb begin
    owner_mask = '0;
    owner_mask[owner_reg] = 1'b1;
    cand = req;
    // An owner whose lock window ran out steps aside for one arbitration,
    // but only if another master is actually waiting.
    if (RR_MODE != 0 && expired && (|(req & ~owner_mask)))
      cand = req & ~owner_mask;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      if (RR_MODE != 0) begin
        idx = int'(last_reg) + 1 + k;
        if (idx >= N_REQ)
          idx = idx - N_REQ;
      end else begin
        idx = k;
      end
      if (!win_found && cand[idx]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(idx);
      end
    end
  end

  // Next-state and bus outputs
  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    last_next     = last_reg;
    cnt_next      = cnt_reg;
    gnt_next      = gnt_reg;
    rd_valid_next = '0;
    mem_addr      = '0;
    mem_data_out  = '0;
    mem_write_en  = 1'b0;
    mem_read_en   = 1'b0;

    if (state_reg == OWN) begin
      mem_addr     = addr_arr[owner_reg];
      mem_data_out = wdata_arr[owner_reg];
      mem_write_en = req[owner_reg] & we[owner_reg] & ~halt;
      // A simultaneous write and read is treated as a write.
      mem_read_en  = req[owner_reg] & re[owner_reg] & ~we[owner_reg] & ~halt;
      // Memory returns read data one cycle later, so the valid strobe is registered.
      if (mem_read_en)
        rd_valid_next = owner_mask;
    end

    if (!halt) begin
      if (state_reg == OWN && req[owner_reg] && lock[owner_reg] && !expired) begin
        cnt_next = cnt_reg + CNT_W'(1);
      end else if (win_found) begin
        state_next = OWN;
        owner_next = win_idx;
        last_next  = win_idx;
        cnt_next   = '0;
        gnt_next   = '0;
        gnt_next[win_idx] = 1'b1;
      end else begin
        state_next = IDLE;
        cnt_next   = '0;
        gnt_next   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      owner_reg    <= '0;
      last_reg     <= LAST_IDX;
      cnt_reg      <= '0;
      gnt_reg      <= '0;
      rd_valid_reg <= '0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      last_reg     <= last_next;
      cnt_reg      <= cnt_next;
      gnt_reg      <= gnt_next;
      rd_valid_reg <= rd_valid_next;
    end
  end

  assign gnt      = gnt_reg;
  assign rd_valid = rd_valid_reg;
  assign busy     = |gnt_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter.
// Runs a fixed-priority instance and a round-robin instance from the same
// stimulus. Each instance is compared every cycle against a behavioural model
// of the arbitration rules.
module tb_mem_bus_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int LM = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, lock, we, re;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic            halt;

  logic [N-1:0]  gnt_fx, rdv_fx, gnt_rr, rdv_rr;
  logic [AW-1:0] maddr_fx, maddr_rr;
  logic [DW-1:0] mdo_fx, mdo_rr;
  logic          mwe_fx, mre_fx, busy_fx, mwe_rr, mre_rr, busy_rr;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0), .LOCK_MAX(LM)) dut_fx (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .re(re),
    .addr(addr), .wdata(wdata), .halt(halt),
    .gnt(gnt_fx), .mem_addr(maddr_fx), .mem_data_out(mdo_fx),
    .mem_write_en(mwe_fx), .mem_read_en(mre_fx), .rd_valid(rdv_fx), .busy(busy_fx)
  );

  mem_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1), .LOCK_MAX(LM)) dut_rr (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .re(re),
    .addr(addr), .wdata(wdata), .halt(halt),
    .gnt(gnt_rr), .mem_addr(maddr_rr), .mem_data_out(mdo_rr),
    .mem_write_en(mwe_rr), .mem_read_en(mre_rr), .rd_valid(rdv_rr), .busy(busy_rr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model state, index 0 = fixed priority, 1 = round robin.
  // owner = -1 means the bus is idle; hold counts locked cycles in this tenure.
  int           m_owner [2];
  int           m_hold  [2];
  int           m_last  [2];
  logic [N-1:0] m_rdv   [2];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = -1;
      m_hold[m]  = 0;
      m_last[m]  = N - 1;
      m_rdv[m]   = '0;
    end
  endtask

  // Advance the model across one rising edge, using the inputs of the cycle just ending.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      int o, excl, w, idx;
      logic [N-1:0] rn;
      logic keep;
      o  = m_owner[m];
      rn = '0;
      if (o >= 0 && req[o] && re[o] && !we[o] && !halt)
        rn[o] = 1'b1;
      if (!halt) begin
        keep = (o >= 0) && req[o] && lock[o] && (m_hold[m] < LM - 1);
        if (keep) begin
          m_hold[m]++;
        end else begin
          excl = -1;
          if (m == 1 && o >= 0 && m_hold[m] == LM - 1 && ((req & ~(N'(1) << o)) != '0))
            excl = o;
          w = -1;
          for (int k = 0; k < N; k++) begin
            idx = (m == 1) ? (m_last[m] + 1 + k) % N : k;
            if (w < 0 && req[idx] && idx != excl)
              w = idx;
          end
          m_owner[m] = w;
          m_hold[m]  = 0;
          if (w >= 0)
            m_last[m] = w;
        end
      end
      m_rdv[m] = rn;
    end
  endtask

  task automatic check_mode(input int m, input string nm,
                            input logic [N-1:0] g, input logic [N-1:0] rdv,
                            input logic [AW-1:0] ma, input logic [DW-1:0] md,
                            input logic mwe, input logic mre, input logic bsy);
    int o;
    logic [N-1:0]  eg;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          ew, er;
    o  = m_owner[m];
    eg = '0; ea = '0; ed = '0; ew = 1'b0; er = 1'b0;
    if (o >= 0) begin
      eg[o] = 1'b1;
      ea = addr[o*AW +: AW];
      ed = wdata[o*DW +: DW];
      ew = req[o] && we[o] && !halt;
      er = req[o] && re[o] && !we[o] && !halt;
    end
    check_eq({nm, ".gnt"},      64'(g),   64'(eg));
    check_eq({nm, ".rd_valid"}, 64'(rdv), 64'(m_rdv[m]));
    check_eq({nm, ".mem_addr"}, 64'(ma),  64'(ea));
    check_eq({nm, ".mem_data"}, 64'(md),  64'(ed));
    check_eq({nm, ".write_en"}, 64'(mwe), 64'(ew));
    check_eq({nm, ".read_en"},  64'(mre), 64'(er));
    check_eq({nm, ".busy"},     64'(bsy), 64'(eg != '0));
  endtask

  task automatic check_all();
    check_mode(0, "fx", gnt_fx, rdv_fx, maddr_fx, mdo_fx, mwe_fx, mre_fx, busy_fx);
    check_mode(1, "rr", gnt_rr, rdv_rr, maddr_rr, mdo_rr, mwe_rr, mre_rr, busy_rr);
  endtask

  // One bus cycle: inputs were set just after the previous rising edge.
  task automatic run_cycle();
    @(negedge clk);
    check_all();
    $display("cyc %0d req=%b lock=%b we=%b re=%b halt=%b gnt_fx=%b gnt_rr=%b rdv_fx=%b rdv_rr=%b",
             cyc, req, lock, we, re, halt, gnt_fx, gnt_rr, rdv_fx, rdv_rr);
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_in(input logic [N-1:0] r, input logic [N-1:0] l,
                        input logic [N-1:0] w, input logic [N-1:0] rd, input logic h);
    req = r; lock = l; we = w; re = rd; halt = h;
    addr  = {$urandom, $urandom};
    wdata = $urandom;
  endtask

  // Asynchronous reset in the middle of a cycle: outputs must clear at once.
  task automatic mid_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    set_in(4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0);
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // First grant after reset: index 0 in both modes.
    run_cycle();
    check_eq("post_reset.gnt_fx", 64'(gnt_fx), 64'(4'b0001));
    check_eq("post_reset.gnt_rr", 64'(gnt_rr), 64'(4'b0001));

    // Fixed priority with req[1] and req[3], then req[1] leaves.
    for (int i = 0; i < 3; i++) begin set_in(4'b1010, 4'b0000, 4'b0000, 4'b0000, 1'b0); run_cycle(); end
    for (int i = 0; i < 2; i++) begin set_in(4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0); run_cycle(); end

    // Everyone requesting, no lock: rotation in round-robin mode.
    for (int i = 0; i < 6; i++) begin set_in(4'b1111, 4'b0000, 4'b0000, 4'b0000, 1'b0); run_cycle(); end

    // Locked owner 0 against requester 1 until the lock window expires.
    for (int i = 0; i < 7; i++) begin set_in(4'b0011, 4'b0001, 4'b0000, 4'b0000, 1'b0); run_cycle(); end

    // Reads from requester 2 at 16'h2002, then write and read together.
    for (int i = 0; i < 6; i++) begin
      set_in(4'b0100, 4'b0000, (i >= 3) ? 4'b0100 : 4'b0000, 4'b0100, 1'b0);
      addr[2*AW +: AW] = 16'h2002;
      run_cycle();
    end

    // Halt in the middle of a rotation, with reads in flight.
    for (int i = 0; i < 2; i++) begin set_in(4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b0); run_cycle(); end
    for (int i = 0; i < 3; i++) begin set_in(4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b1); run_cycle(); end
    for (int i = 0; i < 4; i++) begin set_in(4'b1111, 4'b0000, 4'b0000, 4'b1111, 1'b0); run_cycle(); end

    // Reset while a read is outstanding.
    mid_reset();

    // Randomised traffic in phases of light and heavy locking.
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] l;
      l = ((i / 100) % 2 == 1) ? N'($urandom) : N'($urandom & $urandom);
      set_in(N'($urandom), l, N'($urandom), N'($urandom), ($urandom_range(9, 0) == 0));
      if (i == 350)
        mid_reset();
      run_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
